mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter and sequencer for the single simulation memory port (`men`/`mwen`/`raddr`/`waddr`/`wdata`/`wmask`/`rdata`) driven into the DPI memory model. It shares that port between instruction fetch (read-only) and load/store (read/write) using valid/ready handshakes. It issues exactly one single-cycle memory strobe per transaction, captures read data after a fixed latency, and returns a response to the owning requester. LSU has priority, with a starvation guard for IF.

## Interface
- `MEM_LAT`, 0: cycles between the issue cycle and the rdata capture edge; 0 means rdata is captured at the edge ending the issue cycle.
- `STARVE_MAX`, 4: consecutive LSU grants with IF pending, after which IF wins once.
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req_valid` in 1 / `if_req_ready` out 1 / `if_req_addr` in 64: IF read request.
- `if_resp_valid` out 1 / `if_resp_ready` in 1 / `if_resp_data` out 64: IF read response.
- `ls_req_valid` in 1 / `ls_req_ready` out 1: LSU request handshake.
- `ls_req_we` in 1 / `ls_req_addr` in 64 / `ls_req_wdata` in 64 / `ls_req_wmask` in 8: LSU request payload.
- `ls_resp_valid` out 1 / `ls_resp_ready` in 1 / `ls_resp_data` out 64: LSU response. Writes return data 0 as a completion ack.
- `men` out 1 / `mwen` out 1: memory enable and write enable.
- `raddr` out 64 / `waddr` out 64 / `wdata` out 64 / `wmask` out 8: memory request fields.
- `rdata` in 64: memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Grant is combinational. LSU wins if `ls_req_valid`, unless `streak==STARVE_MAX` and `if_req_valid`. Otherwise IF wins if valid.
  - Only the granted side's `*_req_ready` is 1. The other side's ready is 0.
  - On handshake: latch owner, we, addr, wdata, wmask, then go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - `men=1`; `mwen=we`.
  - `raddr=waddr=`latched addr; `wdata`/`wmask` = latched values. For a read, `wmask=0`.
  - If `MEM_LAT==0`: capture `rdata` (reads) at this edge, go to RESP. Otherwise go to WAIT.
- **WAIT**
  - A counter counts `MEM_LAT` cycles with `men=0`.
  - On the final WAIT cycle's edge: capture `rdata`, go to RESP.
- **RESP**
  - Owner's `*_resp_valid=1`. Data is held stable until that side's `*_resp_ready`.
  - On handshake: go to IDLE.
- **Starvation counter `streak`** (width `$clog2(STARVE_MAX+1)`, saturating)
  - Increments on an LSU grant while `if_req_valid=1`.
  - Clears on an IF grant, or on an IDLE cycle with `if_req_valid=0`.
- Memory fields outside ISSUE are driven 0, so no stray DPI calls are made.

## Timing
- **Reset values**: every output is 0; state=IDLE; `streak=0`; latched payload=0.
- **Asynchronous reset mid-transaction**:
  - `men`/`mwen` drop immediately and the in-flight transaction is dropped.
  - No response is issued, and no memory op happens until a new request is accepted.
- **Latency**: request accepted at edge T, ISSUE in cycle T+1, `resp_valid` from cycle T+2+MEM_LAT.
- **Throughput**: minimum 3+MEM_LAT cycles per transaction (RESP accepted immediately).
- No new request is accepted while in ISSUE, WAIT, or RESP. Both req_readys are 0 there.
- Requesters must hold payload stable while valid and not ready. Dropping valid before handshake withdraws the request.
- **Simultaneous valid** in IDLE: priority rule above. Ties never grant both.
- A response stalled by `resp_ready=0` blocks the port indefinitely. This is intended: one outstanding transaction.

## Structure
- `mem_arbiter_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - the owner enum (OWN_IF/OWN_LS);
  - the 64-bit addr/data width constants and the 8-bit mask width.
- Sub-module `mem_arb_grant` contains the combinational grant decision plus the `streak` counter. The top holds the FSM, the latency counter and the latches.

## Test plan
- **Reset**: assert `rst_n=0` at any state. Required: all outputs 0 within the same cycle, and the FSM in IDLE after release.
- **IF read, MEM_LAT=0**: `if_req_addr=0x80000000`, memory returns `0x00000297DEADBEEF`. Required:
  - `men=1`, `mwen=0` for exactly 1 cycle;
  - `if_resp_data=0x00000297DEADBEEF` two cycles after accept.
- **LSU write, MEM_LAT=2**: addr `0x80001000`, wdata `0x1122334455667788`, wmask `0x0F`. Required:
  - `mwen=1` for 1 cycle with those fields;
  - `ls_resp_valid` with data 0 at T+4.
- **Both valid continuously, STARVE_MAX=4**. Required grant order: LS,LS,LS,LS,IF,LS,...
- **Response backpressure**: hold `ls_resp_ready=0` for 5 cycles. Required:
  - data stable;
  - no further `men`;
  - `if_req_ready` stays 0.
- **Reset asserted during WAIT**. Required:
  - no response;
  - the next accepted request issues normally with correct data.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the two-requester memory port arbiter.
package mem_arbiter_pkg;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes plus the single memory port, bundled for the arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // valid/ready: a transfer happens on a rising edge where both are 1; the
  // sender holds its payload stable while valid=1 and ready=0.
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_resp_valid;
  logic              if_resp_ready;
  logic [DATA_W-1:0] if_resp_data;

  logic              ls_req_valid;
  logic              ls_req_ready;
  logic              ls_req_we;
  logic [ADDR_W-1:0] ls_req_addr;
  logic [DATA_W-1:0] ls_req_wdata;
  logic [MASK_W-1:0] ls_req_wmask;
  logic              ls_resp_valid;
  logic              ls_resp_ready;
  logic [DATA_W-1:0] ls_resp_data;

  logic              men;
  logic              mwen;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [MASK_W-1:0] wmask;
  logic [DATA_W-1:0] rdata;

  modport slave (
    input  if_req_valid, if_req_addr, if_resp_ready,
    input  ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata, ls_req_wmask, ls_resp_ready,
    input  rdata,
    output if_req_ready, if_resp_valid, if_resp_data,
    output ls_req_ready, ls_resp_valid, ls_resp_data,
    output men, mwen, raddr, waddr, wdata, wmask
  );

  modport master (
    output if_req_valid, if_req_addr, if_resp_ready,
    output ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata, ls_req_wmask, ls_resp_ready,
    output rdata,
    input  if_req_ready, if_resp_valid, if_resp_data,
    input  ls_req_ready, ls_resp_valid, ls_resp_data,
    input  men, mwen, raddr, waddr, wdata, wmask
  );
endinterface

// File: rtl/mem_arb_grant.sv
// Combinational IDLE grant with LSU priority and a saturating IF starvation streak.
module mem_arb_grant #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle_i,
  input  logic if_valid_i,
  input  logic ls_valid_i,
  output logic gnt_if_o,
  output logic gnt_ls_o
);
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [SW-1:0] streak_q, streak_d;
  logic          starve;

  assign starve   = (streak_q == SW'(STARVE_MAX));
  assign gnt_ls_o = idle_i && ls_valid_i && !(starve && if_valid_i);
  assign gnt_if_o = idle_i && if_valid_i && !gnt_ls_o;

  // Only IDLE cycles move the streak; busy cycles leave it untouched.
  always_comb begin
    streak_d = streak_q;
    if (idle_i) begin
      if (gnt_if_o || !if_valid_i) begin
        streak_d = '0;
      end else if (gnt_ls_o && !starve) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) streak_q <= '0;
    else        streak_q <= streak_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IF (read) and LSU (read/write): one strobe
// per transaction, fixed-latency read capture, response to the owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus,
  output state_e       state_o
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic idle, issue, resp, gnt_if, gnt_ls, resp_fire;
  logic [DATA_W-1:0] rd_val;

  assign idle   = (state_q == ST_IDLE);
  assign issue  = (state_q == ST_ISSUE);
  assign resp   = (state_q == ST_RESP);
  assign rd_val = we_q ? '0 : bus.rdata;
  assign resp_fire = resp && ((owner_q == OWN_IF) ? bus.if_resp_ready : bus.ls_resp_ready);

  mem_arb_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
    .clk        (clk),
    .rst_n      (rst_n),
    .idle_i     (idle),
    .if_valid_i (bus.if_req_valid),
    .ls_valid_i (bus.ls_req_valid),
    .gnt_if_o   (gnt_if),
    .gnt_ls_o   (gnt_ls)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_ls) begin
          owner_d = OWN_LS;
          we_d    = bus.ls_req_we;
          addr_d  = bus.ls_req_addr;
          wdata_d = bus.ls_req_wdata;
          wmask_d = bus.ls_req_wmask;
          state_d = ST_ISSUE;
        end else if (gnt_if) begin
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = bus.if_req_addr;
          wdata_d = '0;
          wmask_d = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Zero latency means the memory answers within the strobe cycle.
        if (MEM_LAT == 0) begin
          data_d  = rd_val;
          state_d = ST_RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          data_d  = rd_val;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory fields are zero outside ISSUE so the model sees no stray accesses.
  assign bus.men   = issue;
  assign bus.mwen  = issue && we_q;
  assign bus.raddr = issue ? addr_q : '0;
  assign bus.waddr = issue ? addr_q : '0;
  assign bus.wdata = issue ? wdata_q : '0;
  assign bus.wmask = (issue && we_q) ? wmask_q : '0;

  assign bus.if_req_ready  = gnt_if;
  assign bus.ls_req_ready  = gnt_ls;
  assign bus.if_resp_valid = resp && (owner_q == OWN_IF);
  assign bus.ls_resp_valid = resp && (owner_q == OWN_LS);
  assign bus.if_resp_data  = bus.if_resp_valid ? data_q : '0;
  assign bus.ls_resp_data  = bus.ls_resp_valid ? data_q : '0;

  assign state_o = state_q;
endmodule
